// File: rtl/pulse_train_generator.sv
// pulse_train_generator
//   Captures a WIDTH-bit pattern and shifts it out on `pulse`, one bit per
//   clock. A burst is one pass, repeat_cnt+1 passes, or continuous until
//   stopped. All outputs are registered.
//
// Ports:
//   Clk        rising-edge clock
//   Reset_n    asynchronous active-low reset
//   load       capture `value` into the pattern register (IDLE only)
//   value      pattern to capture
//   start      begin a burst (IDLE only)
//   repeat_cnt extra passes after the first, sampled on start
//   continuous repeat until stop, sampled on start (overrides repeat_cnt)
//   stop       abort the burst (no done strobe)
//   pulse      serial pattern bit
//   busy       high while a burst is running
//   done       one-cycle strobe after normal completion
module pulse_train_generator #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             continuous,
  input  logic             stop,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pattern, pattern_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mode, mode_n;
  logic             pulse_n, busy_n, done_n;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] shreg_adv;

  function automatic logic head(input logic [WIDTH-1:0] p);
    return (LSB_FIRST != 0) ? p[0] : p[WIDTH-1];
  endfunction

  // A simultaneous load+start transmits the freshly loaded value.
  assign src = load ? value : pattern;

  // The shift register keeps the bit currently on `pulse` at its head, so the
  // registered pulse for the next cycle is the head of the advanced register.
  assign shreg_adv = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      pattern <= '0;
      shreg   <= '0;
      idx     <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pattern <= pattern_n;
      shreg   <= shreg_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      mode    <= mode_n;
      pulse   <= pulse_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    shreg_n   = shreg;
    idx_n     = idx;
    cnt_n     = cnt;
    mode_n    = mode;
    pulse_n   = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (load) pattern_n = value;
        if (start) begin
          state_n = RUN;
          shreg_n = src;
          idx_n   = '0;
          cnt_n   = repeat_cnt;
          mode_n  = continuous;
          pulse_n = head(src);
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (idx == LAST) begin
          if (mode || (cnt != '0)) begin
            if (!mode) cnt_n = cnt - CNT_W'(1);
            shreg_n = pattern;
            idx_n   = '0;
            pulse_n = head(pattern);
            busy_n  = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          shreg_n = shreg_adv;
          idx_n   = idx + IDX_W'(1);
          pulse_n = head(shreg_adv);
          busy_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator
//   Drives an LSB-first and an MSB-first instance with the same stimulus.
//   Expected {pulse,busy,done} per output cycle are queued at stimulus time;
//   a monitor pops and compares whenever an instance is active.
module tb_pulse_train_generator;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] value;
  logic       start;
  logic [3:0] repeat_cnt;
  logic       continuous;
  logic       stop;
  logic       pulse_a, busy_a, done_a;
  logic       pulse_b, busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] qa[$];
  logic [2:0] qb[$];

  pulse_train_generator #(.WIDTH(8), .CNT_W(4), .LSB_FIRST(1)) dut_lsb (
    .Clk(clk), .Reset_n(rst_n), .load(load), .value(value), .start(start),
    .repeat_cnt(repeat_cnt), .continuous(continuous), .stop(stop),
    .pulse(pulse_a), .busy(busy_a), .done(done_a)
  );

  pulse_train_generator #(.WIDTH(8), .CNT_W(4), .LSB_FIRST(0)) dut_msb (
    .Clk(clk), .Reset_n(rst_n), .load(load), .value(value), .start(start),
    .repeat_cnt(repeat_cnt), .continuous(continuous), .stop(stop),
    .pulse(pulse_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: pulse/busy/done got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // One full burst: `passes` passes of `pat`, then the done cycle.
  task automatic push_burst(input logic [7:0] pat, input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 8; i++) begin
        qa.push_back({pat[i], 1'b1, 1'b0});
        qb.push_back({pat[7-i], 1'b1, 1'b0});
      end
    qa.push_back(3'b001);
    qb.push_back(3'b001);
  endtask

  // Called just after a rising edge; returns just after the edge that sampled start.
  task automatic start_burst(input logic [7:0] pat, input bit do_load,
                             input logic [3:0] rc, input bit cont);
    if (do_load) begin
      load  = 1'b1;
      value = pat;
    end
    start      = 1'b1;
    repeat_cnt = rc;
    continuous = cont;
    @(posedge clk); #1;
    load       = 1'b0;
    start      = 1'b0;
    repeat_cnt = '0;
    continuous = 1'b0;
  endtask

  // Monitor: active cycles, plus the cycle right after busy falls (catches
  // early drop of busy and checks the post-stop idle cycle).
  initial begin
    logic prev_a, prev_b;
    logic [2:0] e;
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_a = 1'b0;
        prev_b = 1'b0;
      end else begin
        if (busy_a || done_a || prev_a) begin
          if (qa.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL lsb_unexpected: pulse/busy/done got %b required no activity at %0t",
                     {pulse_a, busy_a, done_a}, $time);
          end else begin
            e = qa.pop_front();
            check3("lsb_stream", {pulse_a, busy_a, done_a}, e);
          end
        end
        if (busy_b || done_b || prev_b) begin
          if (qb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL msb_unexpected: pulse/busy/done got %b required no activity at %0t",
                     {pulse_b, busy_b, done_b}, $time);
          end else begin
            e = qb.pop_front();
            check3("msb_stream", {pulse_b, busy_b, done_b}, e);
          end
        end
        prev_a = busy_a;
        prev_b = busy_b;
      end
    end
  end

  initial begin
    logic [7:0] p01;
    rst_n = 1'b0; load = 1'b0; value = '0; start = 1'b0;
    repeat_cnt = '0; continuous = 1'b0; stop = 1'b0;

    // Reset state
    #3;
    check3("reset_lsb", {pulse_a, busy_a, done_a}, 3'b000);
    check3("reset_msb", {pulse_b, busy_b, done_b}, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check3("post_reset_lsb", {pulse_a, busy_a, done_a}, 3'b000);
    check3("post_reset_msb", {pulse_b, busy_b, done_b}, 3'b000);

    // Single pass of B2, load in a separate cycle
    load = 1'b1; value = 8'hB2;
    @(posedge clk); #1;
    load = 1'b0;
    push_burst(8'hB2, 1);
    start_burst(8'hB2, 1'b0, 4'd0, 1'b0);
    repeat (8) @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Three contiguous passes
    push_burst(8'hB2, 3);
    start_burst(8'hB2, 1'b0, 4'd2, 1'b0);
    repeat (24) @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Continuous 01, stop sampled at the end of the 13th RUN cycle
    p01 = 8'h01;
    for (int i = 0; i < 13; i++) begin
      qa.push_back({p01[i % 8], 1'b1, 1'b0});
      qb.push_back({p01[7 - (i % 8)], 1'b1, 1'b0});
    end
    qa.push_back(3'b000);
    qb.push_back(3'b000);
    start_burst(8'h01, 1'b1, 4'd0, 1'b1);
    repeat (12) @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (3) @(posedge clk); #1;

    // load/start during RUN are ignored
    push_burst(8'hB2, 2);
    start_burst(8'hB2, 1'b1, 4'd1, 1'b0);
    repeat (3) @(posedge clk); #1;
    load = 1'b1; value = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    repeat (12) @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;

    // load+start together, then restart in the done cycle
    push_burst(8'h0F, 1);
    start_burst(8'h0F, 1'b1, 4'd0, 1'b0);
    repeat (8) @(posedge clk); #1;
    push_burst(8'h0F, 1);
    start_burst(8'h0F, 1'b0, 4'd0, 1'b0);
    repeat (8) @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset mid-pass clears outputs and the pattern
    push_burst(8'h0F, 1);
    start_burst(8'h0F, 1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check3("async_reset_lsb", {pulse_a, busy_a, done_a}, 3'b000);
    check3("async_reset_msb", {pulse_b, busy_b, done_b}, 3'b000);
    qa.delete();
    qb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_burst(8'h00, 1);
    start_burst(8'h00, 1'b0, 4'd0, 1'b0);
    repeat (8) @(posedge clk); #1;

    // Drain with a bounded wait
    for (int t = 0; t < 50 && (qa.size() != 0 || qb.size() != 0); t++)
      @(posedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending entries got %0d/%0d required 0/0", qa.size(), qb.size());
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
